// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer-width derivation and parameter legality.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned depth, input int unsigned af_level,
                                      input int unsigned ae_level);
    return is_pow2(depth) && (depth >= 2) && (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer-facing signal bundle of sync_fifo; the FIFO uses the slave modport.
interface sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, data_in, r_en, clr_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en, clr_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned AW        = ptr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: count-based flags, sticky error flags, registered or FWFT read port.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 1,
    parameter bit          FWFT       = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    sync_fifo_if.slave  bus
);
    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FullCnt = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AfCnt   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] AeCnt   = CNT_WIDTH'(AE_LEVEL);

    if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  full, empty, wr_acc, rd_acc;

    assign full   = (count_q == FullCnt);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.w_en & ~full;
    assign rd_acc = bus.r_en & ~empty;

    always_comb begin
        wptr_d   = wr_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = rd_acc ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set beats clear when both happen in one cycle.
        ovf_d    = (bus.w_en & full) | (ovf_q & ~bus.clr_err);
        udf_d    = (bus.r_en & empty) | (udf_q & ~bus.clr_err);
        dout_d   = rd_acc ? ram_rdata : dout_q;
        dvalid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Gate the write with reset so a w_en in the reset cycle cannot touch memory.
    sync_fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc & rst_n),
        .waddr_i (wptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AfCnt);
    assign bus.almost_empty = (count_q <= AeCnt);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    if (FWFT) begin : g_fwft
        assign bus.data_out   = ram_rdata;
        assign bus.data_valid = ~empty;
    end else begin : g_registered
        assign bus.data_out   = dout_q;
        assign bus.data_valid = dvalid_q;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Drives a registered-read and an FWFT sync_fifo with identical stimulus and checks both.
module tb_sync_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) if0 ();
    sync_fifo_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) if1 ();

    sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );
    sync_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct {
        bit         w, r, clr;
        logic [7:0] din;
        int         cnt;
        bit         ovf, udf, dv0;
        logic [7:0] dout0, head;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_fail = 0;

    // Reference model: queue contents plus the registered-mode output word.
    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_dv0;
    logic [7:0] m_dout0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input bit m, input int cnt, input bit ovf, input bit udf);
        logic [5:0] act, exp;
        logic [3:0] c;
        c   = m ? if1.count : if0.count;
        act = m ? {if1.full, if1.empty, if1.almost_full, if1.almost_empty, if1.overflow,
                   if1.underflow}
                : {if0.full, if0.empty, if0.almost_full, if0.almost_empty, if0.overflow,
                   if0.underflow};
        exp = {cnt == 8, cnt == 0, cnt >= 6, cnt <= 1, ovf, udf};
        chk(m ? "count_fwft" : "count_reg", 32'(c), 32'(cnt));
        chk(m ? "flags_fwft(f,e,af,ae,ov,un)" : "flags_reg(f,e,af,ae,ov,un)",
            32'(act), 32'(exp));
    endtask

    task automatic drive(input bit w, input bit r, input bit clr, input logic [7:0] din);
        if0.w_en = w;   if1.w_en = w;
        if0.r_en = r;   if1.r_en = r;
        if0.clr_err = clr; if1.clr_err = clr;
        if0.data_in = din; if1.data_in = din;
    endtask

    task automatic step(input bit w, input bit r, input bit clr, input logic [7:0] din);
        bit fl, em;
        drive(w, r, clr, din);
        fl = (q.size() == 8);
        em = (q.size() == 0);
        m_dv0 = r && !em;
        if (m_dv0) m_dout0 = q.pop_front();
        if (w && !fl) q.push_back(din);
        m_ovf = (w && fl) || (m_ovf && !clr);
        m_udf = (r && em) || (m_udf && !clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk_dut(1'b0, q.size(), m_ovf, m_udf);
        chk_dut(1'b1, q.size(), m_ovf, m_udf);
        chk("dv_reg", 32'(if0.data_valid), 32'(m_dv0));
        chk("dout_reg", 32'(if0.data_out), 32'(m_dout0));
        chk("dv_fwft", 32'(if1.data_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("dout_fwft", 32'(if1.data_out), 32'(q[0]));
    endtask

    task automatic do_reset(input bit w);
        rst_n = 1'b0;
        drive(w, 1'b0, 1'b0, 8'hEE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        q.delete();
        m_ovf = 0; m_udf = 0; m_dv0 = 0; m_dout0 = 8'h00;
        check_model();
    endtask

    initial begin
        vec_t v;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        do_reset(1'b0);

        // Fill 0x10..0x17, overflow attempt, drain, then underflow/clear ordering.
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1, 0, 0, 8'h10 + 8'(i), i + 1, 0, 0, 0, 8'h00, 8'h10});
        tbl.push_back('{1, 0, 0, 8'hAA, 8, 1, 0, 0, 8'h00, 8'h10});
        tbl.push_back('{0, 0, 1, 8'h00, 8, 0, 0, 0, 8'h00, 8'h10});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, 1, 0, 8'h00, 7 - i, 0, 0, 1, 8'h10 + 8'(i), 8'h11 + 8'(i)});
        tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h17, 8'h00});
        tbl.push_back('{0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h17, 8'h00});
        tbl.push_back('{0, 1, 1, 8'h00, 0, 0, 1, 0, 8'h17, 8'h00});
        tbl.push_back('{0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h17, 8'h00});

        foreach (tbl[k]) begin
            v = tbl[k];
            step(v.w, v.r, v.clr, v.din);
            chk_dut(1'b0, v.cnt, v.ovf, v.udf);
            chk_dut(1'b1, v.cnt, v.ovf, v.udf);
            chk("tbl_dv_reg", 32'(if0.data_valid), 32'(v.dv0));
            chk("tbl_dout_reg", 32'(if0.data_out), 32'(v.dout0));
            chk("tbl_dv_fwft", 32'(if1.data_valid), 32'(v.cnt != 0));
            if (v.cnt != 0) chk("tbl_dout_fwft", 32'(if1.data_out), 32'(v.head));
        end

        // Simultaneous access at full, then at empty.
        for (int i = 0; i < 8; i++) begin step(1, 0, 0, 8'h20 + 8'(i)); check_model(); end
        step(1, 1, 0, 8'hBB); check_model();
        chk("full_rw_count", 32'(if0.count), 32'd7);
        step(0, 0, 1, 8'h00); check_model();
        for (int i = 0; i < 7; i++) begin step(0, 1, 0, 8'h00); check_model(); end
        step(1, 1, 0, 8'hCC); check_model();
        chk("empty_rw_count", 32'(if1.count), 32'd1);
        step(0, 0, 1, 8'h00); check_model();

        // Count 4 with 20 read/write pairs, then occupancy 3 with 20 pairs: pointers wrap.
        for (int i = 0; i < 3; i++) begin step(1, 0, 0, 8'h30 + 8'(i)); check_model(); end
        for (int i = 0; i < 20; i++) begin step(1, 1, 0, 8'h40 + 8'(i)); check_model(); end
        step(0, 1, 0, 8'h00); check_model();
        for (int i = 0; i < 20; i++) begin step(1, 1, 0, 8'h60 + 8'(i)); check_model(); end

        // Mid-operation reset with w_en held high.
        while (q.size() < 5) begin step(1, 0, 0, 8'h70); check_model(); end
        do_reset(1'b1);
        step(1, 0, 0, 8'h55); check_model();
        step(0, 1, 0, 8'h00); check_model();
        chk("post_reset_first_word", 32'(if0.data_out), 32'h55);

        // Randomised traffic with shifting write/read bias so both boundaries are visited.
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = ((i / 75) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
                     $urandom_range(0, 19) == 0, 8'($urandom));
                check_model();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that generalises the team's dual-clock pointer/flag scheme into one clock domain. Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable read mode: registered or first-word-fall-through. Used as the intra-domain buffer between pipeline stages, where the dual-clock FIFO's synchroniser latency is unnecessary.

## Interface
- DEPTH, 8: number of entries; power of two, ≥ 2.
- DATA_WIDTH, 8: word width in bits.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read, 1 = first-word-fall-through.
- PTR_WIDTH (localparam): $clog2(DEPTH).

Ports (the reset is synchronous and active-low):
- clk  in  1  the single clock; all state changes on posedge clk.
- rst_n  in  1  reset; synchronous, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (FWFT=0) or pop/acknowledge (FWFT=1).
- clr_err  in  1  clears overflow and underflow.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- A write is accepted when w_en & !full. The write stores data_in at the write pointer and increments the write pointer.
- A read is accepted when r_en & !empty. The read increments the read pointer.
- Pointers are PTR_WIDTH bits and wrap from DEPTH-1 to 0 with no special handling. Occupancy comes only from count; there is no pointer-MSB comparison.
- count update: +1 on a write-only cycle, -1 on a read-only cycle, unchanged when both are accepted or neither is.
- All flags decode combinationally from the registered count, so they change in the same cycle as count.
- Simultaneous w_en & r_en:
  - When 0 < count < DEPTH, both are accepted and count is unchanged.
  - When full, the read is accepted, the write is rejected, and overflow sets.
  - When empty, the write is accepted, the read is rejected, and underflow sets.
- overflow sets on w_en & full. underflow sets on r_en & empty. Both hold until clr_err. If set and clear occur in the same cycle, set wins.
- A rejected access changes no pointer, no count and no memory entry.
- FWFT=0:
  - data_out is registered. It loads mem[rptr] on the edge that accepts the read.
  - data_valid pulses high for exactly the following cycle.
  - data_out holds its last value otherwise.
- FWFT=1:
  - data_out = mem[rptr] combinationally and data_valid = !empty.
  - r_en acts as a pop. The next word, or empty, appears after the edge.
- Reset with rst_n = 0 at a clk edge:
  - Pointers and count return to 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - data_valid = 0, data_out = 0 (FWFT=0), overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset in the middle of operation discards all stored words. Any w_en or r_en in the reset cycle is ignored.

## Timing
- Write-to-visibility: a word written at edge N is readable from edge N, so empty deasserts after edge N. In FWFT=1 it appears on data_out in cycle N+1.
- FWFT=0 read latency: r_en accepted at edge N gives data_out and data_valid in cycle N+1.
- FWFT=1 read latency: 0 cycles; the head word is already present when empty is low.
- Flag latency: 0 cycles after the count update, i.e. flags reflect state as of the last edge.
- Full throughput: one write and one read per cycle, sustained indefinitely at mid occupancy.

## Structure
- Shared package fifo_pkg:
  - clog2-based PTR_WIDTH derivation.
  - Parameter legality checks (DEPTH a power of two; AF_LEVEL and AE_LEVEL in range), elaboration-time error on violation.
- Sub-module sync_fifo_ram:
  - DEPTH × DATA_WIDTH storage with a synchronous write port and an asynchronous read port.
  - No reset.
  - Instantiated once.
- The top level holds pointers, count, flags, error registers and the FWFT mux.

## Test plan
Bench configuration: DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=1, run in both FWFT modes.
- Fill, then drain:
  - Stimulus: write 0x10..0x17 on consecutive cycles, then read 8 times.
  - Required: almost_empty deasserts at count=2, almost_full asserts at count=6, full asserts at count=8.
  - Required: data is read back as 0x10..0x17 in order (data_valid timing per mode), and empty=1 at the end.
- Overflow:
  - Stimulus: with the FIFO full, write 0xAA.
  - Required: count stays 8, overflow=1, and 0xAA never appears on data_out.
  - Stimulus: pulse clr_err. Required: overflow=0.
- Underflow:
  - Stimulus: with the FIFO empty, pulse r_en.
  - Required: underflow=1, count=0, data_valid=0 (FWFT=0).
  - Stimulus: assert clr_err together with another empty read. Required: underflow stays 1.
- Simultaneous read/write at boundaries:
  - Stimulus at full: w_en & r_en. Required: count goes to 7 and overflow=1.
  - Stimulus at empty: w_en & r_en. Required: count goes to 1 and underflow=1.
  - Stimulus at count=4: w_en & r_en for 20 cycles. Required: count stays 4 and both pointers wrap.
- Wrap-around:
  - Stimulus: 20 write/read pairs at occupancy 3 with an incrementing pattern.
  - Required: no data loss or reordering across the 7→0 pointer wrap.
- Mid-operation reset:
  - Stimulus: load 5 words, then hold rst_n low for 1 cycle with w_en=1.
  - Required: count=0, empty=1, overflow=underflow=0.
  - Required: the next written word (0x55) is the first word read back.
